// File: rtl/zeta_addr_gen.sv
// rtl/zeta_addr_gen.sv - per-stage twiddle index, valid and completion generator for the dual-lane NTT
// Optional inverse-index mode chain: ZETA_INTT_EN
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 7
`endif

module zeta_addr_gen #(
    parameter int BF_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_intt,
    output logic [`NTT_STAGE_CNT-2:0] rom_addr [2][`NTT_STAGE_CNT],
    output logic [`NTT_STAGE_CNT-1:0] stage_valid,
    output logic                      poly_done,
    output logic                      busy
);
    localparam int S  = `NTT_STAGE_CNT;
    localparam int A  = S - 1;
    localparam int L  = (S - 1) * BF_LAT;
    localparam int ML = (L > 1) ? L - 1 : 1;
    localparam logic [S-1:0] C_EXT = {1'b1, {A{1'b0}}};

    logic         in_beat;
    logic [L-1:0] vchain_q, vchain_d;
    logic [A-1:0] cnt0_q, cnt0_d;
    logic [S-1:0] cnt_nz;
    logic         last_done;
    logic         poly_done_q, poly_done_d;

    // Reset also masks the combinational stage-0 strobe.
    assign in_beat = in_valid & rst_n;

    always_comb begin
        vchain_d    = vchain_q;
        vchain_d[0] = in_beat;
        for (int k = 1; k < L; k++) begin
            vchain_d[k] = vchain_q[k-1];
        end
        cnt0_d      = in_beat ? cnt0_q + 1'b1 : cnt0_q;
        poly_done_d = last_done;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vchain_q    <= '0;
            cnt0_q      <= '0;
            poly_done_q <= 1'b0;
        end else begin
            vchain_q    <= vchain_d;
            cnt0_q      <= cnt0_d;
            poly_done_q <= poly_done_d;
        end
    end

`ifdef ZETA_INTT_EN
    logic          mode_cur;
    logic          mode_q, mode_d;
    logic [ML-1:0] mchain_q, mchain_d;

    // Mode is captured on beat 0 and reused for the rest of the polynomial.
    assign mode_cur = (cnt0_q == '0) ? in_intt : mode_q;

    always_comb begin
        mode_d      = in_beat ? mode_cur : mode_q;
        mchain_d    = mchain_q;
        mchain_d[0] = mode_cur;
        for (int k = 1; k < ML; k++) begin
            mchain_d[k] = mchain_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            mchain_q <= '0;
        end else begin
            mode_q   <= mode_d;
            mchain_q <= mchain_d;
        end
    end
`else
    logic unused_intt;
    assign unused_intt = in_intt;
`endif

    assign stage_valid[0] = in_beat;
    assign rom_addr[0][0] = '0;
    assign rom_addr[1][0] = '0;
    assign cnt_nz[0]      = |cnt0_q;

    for (genvar i = 1; i < S; i++) begin : g_stage
        // The address register is loaded one cycle ahead of the stage strobe,
        // so the counter advances on the chain tap just before it.
        localparam int TAP = i * BF_LAT - 2;
        localparam logic [S-1:0] MASK = {S{1'b1}} >> (S - i);

        logic         pre_v;
        logic         pre_m;
        logic [A-1:0] cnt_q, cnt_d;
        logic [A-1:0] a0_q, a0_d;
        logic [A-1:0] a1_q, a1_d;
        logic [S-1:0] k0, k1;

        if (TAP < 0) begin : g_head
            assign pre_v = in_beat;
`ifdef ZETA_INTT_EN
            assign pre_m = mode_cur;
`else
            assign pre_m = 1'b0;
`endif
        end else begin : g_tap
            assign pre_v = vchain_q[TAP];
`ifdef ZETA_INTT_EN
            assign pre_m = mchain_q[TAP];
`else
            assign pre_m = 1'b0;
`endif
        end

        always_comb begin
            k0 = {1'b0, cnt_q} >> (S - i);
            k1 = ({1'b0, cnt_q} + C_EXT) >> (S - i);
            if (pre_m) begin
                k0 = MASK - k0;
                k1 = MASK - k1;
            end
            cnt_d = pre_v ? cnt_q + 1'b1 : cnt_q;
            a0_d  = pre_v ? k0[A-1:0] : a0_q;
            a1_d  = pre_v ? k1[A-1:0] : a1_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
                a0_q  <= '0;
                a1_q  <= '0;
            end else begin
                cnt_q <= cnt_d;
                a0_q  <= a0_d;
                a1_q  <= a1_d;
            end
        end

        if (i == S - 1) begin : g_last
            assign last_done = pre_v & (&cnt_q);
        end

        assign cnt_nz[i]      = |cnt_q;
        assign stage_valid[i] = vchain_q[i*BF_LAT-1];
        assign rom_addr[0][i] = a0_q;
        assign rom_addr[1][i] = a1_q;
    end

    assign poly_done = poly_done_q;
    assign busy      = (|vchain_q) | (|cnt_nz);

endmodule
